// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   F3_*        : RV32I load/store funct3 encodings
//   lsu_state_t : sequencing states of dmem_lsu
//   MAX_LATENCY : largest supported RAM read latency
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int unsigned MAX_LATENCY = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CAPTURE,
      S_RESP
   } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle of the load/store unit.
//   req_valid/req_ready : request handshake (accept on both high)
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata, rsp_misaligned : response payload
// master = core side, slave = dmem_lsu side.
interface dmem_lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic of the load/store unit.
//   i_we, i_funct3, i_addr_lo : access type and byte offset within the word
//   i_wdata                   : store data (rs2)
//   i_rword                   : raw RAM word for loads
//   o_misaligned              : illegal funct3 or misaligned access
//   o_be, o_wdata             : store byte enables and lane-replicated data
//   o_rdata                   : extracted and sign/zero-extended load data
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic        o_misaligned,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
      w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
   end

   always_comb begin
      o_misaligned = 1'b0;
      o_be         = '0;
      o_wdata      = '0;
      o_rdata      = '0;
      if (i_we) begin
         case (i_funct3)
            F3_SB: begin
               o_be    = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_wdata[7:0]}};
            end
            F3_SH: begin
               o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
               o_wdata      = {2{i_wdata[15:0]}};
               o_misaligned = i_addr_lo[0];
            end
            F3_SW: begin
               o_be         = 4'b1111;
               o_wdata      = i_wdata;
               o_misaligned = |i_addr_lo;
            end
            default: o_misaligned = 1'b1;
         endcase
      end else begin
         case (i_funct3)
            F3_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_rdata = {24'h0, w_byte};
            F3_LH: begin
               o_rdata      = {{16{w_half[15]}}, w_half};
               o_misaligned = i_addr_lo[0];
            end
            F3_LHU: begin
               o_rdata      = {16'h0, w_half};
               o_misaligned = i_addr_lo[0];
            end
            F3_LW: begin
               o_rdata      = i_rword;
               o_misaligned = |i_addr_lo;
            end
            default: o_misaligned = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core's memory stage and a word-wide
// synchronous data RAM with MEM_LATENCY cycles of read latency.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request/response bundle (slave side)
//   mem_addr   : RAM word address (byte address bits [ADDR_W+1:2])
//   mem_wen    : RAM write enable, one cycle per store
//   mem_be     : RAM byte enables
//   mem_wdata  : RAM write data, lane replicated
//   mem_rdata  : RAM read data, MEM_LATENCY cycles after mem_addr
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   dmem_lsu_if.slave         bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned      CNT_W    = $clog2(MAX_LATENCY);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

   lsu_state_t       r_state;
   lsu_state_t       w_next;
   logic             r_we;
   logic [2:0]       r_funct3;
   logic [1:0]       r_addr_lo;
   logic [CNT_W-1:0] r_cnt;

   logic             w_idle;
   logic             w_accept;
   logic             w_sel_we;
   logic [2:0]       w_sel_funct3;
   logic [1:0]       w_sel_lo;
   logic             w_mis;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_rdata;

   assign w_idle        = (r_state == S_IDLE);
   assign bus.req_ready = w_idle;
   assign w_accept      = bus.req_valid && w_idle;

   // One aligner serves both phases: in IDLE it judges the live request and
   // builds store lanes; later it extracts load data using the latched request.
   assign w_sel_we     = w_idle ? bus.req_we             : r_we;
   assign w_sel_funct3 = w_idle ? bus.req_funct3         : r_funct3;
   assign w_sel_lo     = w_idle ? bus.req_addr[1:0]      : r_addr_lo;

   lsu_align u_align (
      .i_we         (w_sel_we),
      .i_funct3     (w_sel_funct3),
      .i_addr_lo    (w_sel_lo),
      .i_wdata      (bus.req_wdata),
      .i_rword      (mem_rdata),
      .o_misaligned (w_mis),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_rdata      (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (w_mis)           w_next = S_RESP;
               else if (bus.req_we) w_next = S_WRITE;
               else                 w_next = S_READ;
            end
         end
         S_WRITE:   w_next = S_RESP;
         S_READ:    if (r_cnt == LAT_LAST) w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_RESP;
         S_RESP:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we               <= 1'b0;
         r_funct3           <= '0;
         r_addr_lo          <= '0;
         r_cnt              <= '0;
         mem_addr           <= '0;
         mem_wen            <= 1'b0;
         mem_be             <= '0;
         mem_wdata          <= '0;
         bus.rsp_valid      <= 1'b0;
         bus.rsp_rdata      <= '0;
         bus.rsp_misaligned <= 1'b0;
      end else begin
         bus.rsp_valid <= (w_next == S_RESP);
         mem_wen       <= (w_next == S_WRITE);
         mem_be        <= (w_next == S_WRITE) ? w_be : '0;

         if (w_accept) begin
            r_we      <= bus.req_we;
            r_funct3  <= bus.req_funct3;
            r_addr_lo <= bus.req_addr[1:0];
            if (!w_mis) mem_addr <= bus.req_addr[ADDR_W+1:2];
            if (!w_mis && bus.req_we) mem_wdata <= w_wdata;
            if (w_mis) begin
               bus.rsp_rdata      <= '0;
               bus.rsp_misaligned <= 1'b1;
            end
         end

         if (r_state == S_READ)
            r_cnt <= (r_cnt == LAT_LAST) ? '0 : r_cnt + 1'b1;

         if (r_state == S_WRITE) begin
            bus.rsp_rdata      <= '0;
            bus.rsp_misaligned <= 1'b0;
         end

         if (r_state == S_CAPTURE) begin
            bus.rsp_rdata      <= w_rdata;
            bus.rsp_misaligned <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios followed by random
// requests, checked against a byte-addressed reference memory model.
module tb_dmem_lsu;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned LAT    = 3;
   localparam int unsigned NWORDS = 1 << ADDR_W;
   localparam int unsigned MEMB   = 4 << ADDR_W;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   dmem_lsu_if bus ();

   dmem_lsu #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_wen   (mem_wen),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: byte-enabled writes, LAT-deep read pipeline, preload port.
   logic [31:0]       ram     [0:NWORDS-1];
   logic [31:0]       rd_pipe [0:LAT-1];
   logic              pl_we;
   logic [ADDR_W-1:0] pl_addr;
   logic [31:0]       pl_data;

   always @(posedge clk) begin
      if (pl_we) ram[pl_addr] <= pl_data;
      else if (mem_wen) begin
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      rd_pipe[0] <= ram[mem_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // Reference model state
   logic [7:0] ref_b [0:MEMB-1];
   int n_vec;
   int n_fail;

   logic [15:0] obs_rdy, obs_rsp, exp_rdy, exp_rsp;
   logic [31:0] exp_a, got_a, wd_b;
   int          ra, rb, n_rsp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_bad(input bit we, input int unsigned f3, input int unsigned addr);
      int unsigned size;
      if (we) begin
         if (f3 > 2) return 1'b1;
      end else begin
         if (f3 == 3 || f3 > 5) return 1'b1;
      end
      size = 32'd1 << (f3 % 4);
      return (addr % size) != 0;
   endfunction

   task automatic preload(input int unsigned w, input logic [31:0] d);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = w[ADDR_W-1:0];
      pl_data = d;
      for (int i = 0; i < 4; i++) ref_b[(4*w + i) % MEMB] = d[8*i +: 8];
      @(posedge clk);
      #1 pl_we = 1'b0;
   endtask

   task automatic ref_store(input logic [31:0] addr, input int unsigned size, input logic [31:0] wd);
      for (int unsigned i = 0; i < size; i++) ref_b[(addr + i) % MEMB] = wd[8*i +: 8];
   endtask

   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
      bit          bad, got;
      int unsigned size, off, lat, k, n_wen, n_leak;
      logic [31:0] exp_rd, exp_wd;
      logic [3:0]  exp_be;
      bad    = model_bad(we, int'(f3), addr % 4);
      size   = 32'd1 << (int'(f3) % 4);
      off    = addr % 4;
      lat    = bad ? 1 : (we ? 2 : LAT + 2);
      exp_rd = '0;
      exp_be = '0;
      exp_wd = '0;
      if (!bad && !we) begin
         for (int unsigned i = 0; i < size; i++)
            exp_rd |= 32'(ref_b[(addr + i) % MEMB]) << (8*i);
         if (f3 < 4 && size < 4 && exp_rd[8*size-1])
            exp_rd |= ~((32'd1 << (8*size)) - 1);
      end
      if (!bad && we) begin
         for (int unsigned i = 0; i < size; i++) exp_be |= 4'(1 << (off + i));
         exp_wd = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                  (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      end

      @(negedge clk);
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      if (!bad && we) ref_store(addr, size, wd);

      k = 0; got = 1'b0; n_wen = 0; n_leak = 0;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            bus.req_valid  = 1'b0;
            bus.req_we     = 1'($urandom_range(0, 1));
            bus.req_funct3 = 3'($urandom_range(0, 7));
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            if (!bad) chk({tag, "/mem_addr"}, 32'(mem_addr), (addr >> 2) % NWORDS);
         end
         if (mem_wen) begin
            n_wen++;
            if (!bad && we) begin
               chk({tag, "/be"}, 32'(mem_be), 32'(exp_be));
               chk({tag, "/wdata"}, mem_wdata, exp_wd);
            end
         end else if (mem_be != 4'b0000) n_leak++;
         if (bus.rsp_valid) got = 1'b1;
      end
      chk({tag, "/latency"}, k, lat);
      chk({tag, "/misaligned"}, 32'(bus.rsp_misaligned), 32'(bad));
      chk({tag, "/rdata"}, bus.rsp_rdata, exp_rd);
      chk({tag, "/wen_cycles"}, n_wen, (!bad && we) ? 1 : 0);
      chk({tag, "/be_idle"}, n_leak, 0);
      @(negedge clk);
      chk({tag, "/pulse"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "/ready_after"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec          = 0;
      n_fail         = 0;
      reset          = 1'b1;
      pl_we          = 1'b0;
      pl_addr        = '0;
      pl_data        = '0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;

      for (int unsigned w = 0; w < NWORDS; w++) preload(w, $urandom);

      // Reset state
      @(negedge clk);
      chk("rst/ready", 32'(bus.req_ready), 32'd1);
      chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst/rsp_mis", 32'(bus.rsp_misaligned), 32'd0);
      chk("rst/mem_wen", 32'(mem_wen), 32'd0);
      chk("rst/mem_be", 32'(mem_be), 32'd0);
      chk("rst/mem_addr", 32'(mem_addr), 32'd0);
      chk("rst/mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      // Directed functional cases
      do_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, "sw100");
      do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, "lw100");
      do_req(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, "sb103");
      do_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, "lb103");
      do_req(1'b0, 3'b100, 32'h0000_0103, 32'h0, "lbu103");
      preload(32'h202 >> 2, 32'h8001_1234);
      do_req(1'b0, 3'b001, 32'h0000_0202, 32'h0, "lh202");
      do_req(1'b0, 3'b101, 32'h0000_0202, 32'h0, "lhu202");
      do_req(1'b0, 3'b001, 32'h0000_0200, 32'h0, "lh200");
      do_req(1'b1, 3'b001, 32'h0000_0042, 32'h1234_5678, "sh042");
      do_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, "lw040");

      // Error requests
      do_req(1'b0, 3'b010, 32'h0000_0102, 32'h0, "lw_mis");
      do_req(1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, "sh_mis");
      do_req(1'b0, 3'b011, 32'h0000_0000, 32'h0, "ld_f3_011");
      do_req(1'b0, 3'b111, 32'h0000_0010, 32'h0, "ld_f3_111");
      do_req(1'b1, 3'b100, 32'h0000_0010, 32'h0, "st_f3_100");

      // Address wrap: upper bits ignored
      do_req(1'b1, 3'b010, 32'hFFFF_F3FC, 32'hCAFE_F00D, "sw_wrap");
      do_req(1'b0, 3'b010, 32'h0000_03FC, 32'h0, "lw_wrap");

      // Back-to-back: request held valid across two transactions
      ra    = LAT + 2;
      rb    = ra + 3;
      wd_b  = $urandom;
      exp_a = {ref_b[32'h103], ref_b[32'h102], ref_b[32'h101], ref_b[32'h100]};
      got_a = '0;
      obs_rdy = '0;
      obs_rsp = '0;
      @(negedge clk);
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_0100;
      bus.req_valid  = 1'b1;
      obs_rdy[0] = bus.req_ready;
      obs_rsp[0] = bus.rsp_valid;
      for (int c = 1; c < 16; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h0000_0104;
            bus.req_wdata  = wd_b;
         end
         if (c == ra + 2) bus.req_valid = 1'b0;
         obs_rdy[c] = bus.req_ready;
         obs_rsp[c] = bus.rsp_valid;
         if (c == ra) got_a = bus.rsp_rdata;
      end
      ref_store(32'h104, 4, wd_b);
      for (int c = 0; c < 16; c++) begin
         exp_rdy[c] = (c == 0) || (c == ra + 1) || (c >= rb + 1);
         exp_rsp[c] = (c == ra) || (c == rb);
      end
      chk("b2b/ready_trace", 32'(obs_rdy), 32'(exp_rdy));
      chk("b2b/rsp_trace", 32'(obs_rsp), 32'(exp_rsp));
      chk("b2b/first_rdata", got_a, exp_a);
      do_req(1'b0, 3'b010, 32'h0000_0104, 32'h0, "b2b_lw104");

      // Reset during READ
      @(negedge clk);
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_0100;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("rst_rd/busy", 32'(bus.req_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_rd/ready", 32'(bus.req_ready), 32'd1);
      n_rsp = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         if (bus.rsp_valid) n_rsp++;
         @(negedge clk);
      end
      chk("rst_rd/no_rsp", n_rsp, 0);

      // Reset during WRITE (the RAM still sees the write on the reset edge)
      wd_b = $urandom;
      @(negedge clk);
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_0020;
      bus.req_wdata  = wd_b;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      ref_store(32'h20, 4, wd_b);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("rst_wr/wen_before", 32'(mem_wen), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_wr/wen_after", 32'(mem_wen), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_wr/ready", 32'(bus.req_ready), 32'd1);
      n_rsp = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.rsp_valid) n_rsp++;
         @(negedge clk);
      end
      chk("rst_wr/no_rsp", n_rsp, 0);
      do_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, "post_rst_lw");

      // Random traffic confined to a small window, upper bits random
      for (int n = 0; n < 300; n++) begin
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom & 32'hFFFF_FC3F, $urandom, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
